// File: rtl/morse_round_ctrl.sv
// Round sequencer around the digit-timer stage: second tick, timer reload, judging, scoring, end of game.
// Build option TIME_BONUS_EN: a correct answer also scores the remaining seconds (ones, clamped to 9).
module morse_round_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int GAP_TICKS  = 2,
  parameter int MAX_ROUNDS = 10,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               answer_valid,
  input  logic               answer_correct,
  input  logic [3:0]         ones,
  input  logic               TimeOut,
  output logic               reconfig,
  output logic               sec_tick,
  output logic [3:0]         round,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         last_result,
  output logic               round_done,
  output logic               game_over,
  output logic [2:0]         state_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);
  localparam logic [SCORE_W+4:0] SCORE_MAX = {5'b0, {SCORE_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_JUDGE = 3'd4,
    S_GAP   = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_presc;
  logic [GW-1:0]      r_gap;
  logic               r_reconfig;
  logic               r_round_done;
  logic               r_game_over;
  logic [3:0]         r_round;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_result;

  logic               w_presc_wrap;
  logic [3:0]         w_inc;
  logic [SCORE_W+4:0] w_sum;
  logic [SCORE_W-1:0] w_score_inc;

`ifdef TIME_BONUS_EN
  logic [3:0] w_ones_sat;
  assign w_ones_sat = (ones > 4'd9) ? 4'd9 : ones;
  assign w_inc      = w_ones_sat + 4'd1;
`else
  logic w_unused_ones;
  assign w_unused_ones = ^ones;
  assign w_inc         = 4'd1;
`endif

  // Sum is computed wide so the clamp sees the true total even when SCORE_W is tiny.
  assign w_sum        = {5'b0, r_score} + {{(SCORE_W + 1){1'b0}}, w_inc};
  assign w_score_inc  = (w_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  assign w_presc_wrap = (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_gap        <= '0;
      r_reconfig   <= 1'b0;
      r_round_done <= 1'b0;
      r_game_over  <= 1'b0;
      r_round      <= '0;
      r_score      <= '0;
      r_result     <= 2'b00;
    end else begin
      r_reconfig   <= 1'b0;
      r_round_done <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_reconfig  <= 1'b1;
            r_game_over <= 1'b0;
            r_round     <= '0;
            r_score     <= '0;
            r_result    <= 2'b00;
          end
        end
        S_LOAD: begin
          r_state <= S_ARM;
          r_presc <= '0;
        end
        // Timer is reloading this cycle, so its TimeOut may still be stale.
        S_ARM: r_state <= S_RUN;
        S_RUN: begin
          r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
          if (answer_valid || TimeOut) begin
            r_state      <= S_JUDGE;
            r_round_done <= 1'b1;
            r_round      <= r_round + 4'd1;
            if (!answer_valid)
              r_result <= 2'b11;
            else if (answer_correct) begin
              r_result <= 2'b01;
              r_score  <= w_score_inc;
            end else
              r_result <= 2'b10;
          end
        end
        S_JUDGE: begin
          r_presc <= '0;
          r_gap   <= '0;
          if (r_round == 4'(MAX_ROUNDS)) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else
            r_state <= S_GAP;
        end
        S_GAP: begin
          r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
          if (w_presc_wrap) begin
            if (r_gap == GAP_LAST) begin
              r_state    <= S_LOAD;
              r_reconfig <= 1'b1;
            end else
              r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign sec_tick    = (r_state == S_RUN) && w_presc_wrap;
  assign reconfig    = r_reconfig;
  assign round       = r_round;
  assign score       = r_score;
  assign last_result = r_result;
  assign round_done  = r_round_done;
  assign game_over   = r_game_over;
  assign state_out   = r_state;

endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
Round sequencer for the Morse game that sits directly around the digit-timer stage. It generates the one-second tick enable that drives the timer countdown and pulses `reconfig` to reload the timer at the start of each round. It consumes the timer's `TimeOut` and remaining-seconds digit, together with the player's answer strobe, to judge each round, keep score and detect end of game.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; must be >= 2.
- GAP_TICKS, 2: idle seconds between rounds; must be >= 1.
- MAX_ROUNDS, 10: rounds per game; range 1..15.
- SCORE_W, 8: score width in bits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; begins a game.
- answer_valid, input, 1: single-cycle pulse; player submitted an answer.
- answer_correct, input, 1: qualifies answer_valid; 1 means the answer is correct.
- ones, input, 4: remaining seconds (BCD 0..9) reported by the timer stage.
- TimeOut, input, 1: level; the timer stage has expired.
- reconfig, output, 1: single-cycle pulse; reloads the timer stage.
- sec_tick, output, 1: single-cycle tick enable to the timer stage.
- round, output, 4: number of completed rounds.
- score, output, SCORE_W: accumulated score, saturating.
- last_result, output, 2: 00 none, 01 correct, 10 wrong, 11 timeout.
- round_done, output, 1: single-cycle pulse when a round is judged.
- game_over, output, 1: level; high while in OVER.
- state_out, output, 3: encoded FSM state, for debug.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; prescaler cleared. Reset overrides every state, including mid-round.
- State encoding: IDLE=0, LOAD=1, ARM=2, RUN=3, JUDGE=4, GAP=5, OVER=6.
- IDLE: `start` moves to LOAD; score, round and last_result are cleared on that edge.
- LOAD (1 cycle):
  - `reconfig`=1 during this cycle only.
  - Prescaler cleared.
  - Next state is ARM.
- ARM (1 cycle): `TimeOut` and `answer_valid` are ignored, so a stale timeout is masked while the timer reloads. Next state is RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - `sec_tick`=1 for exactly the cycle the count equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after entry to RUN.
  - `answer_valid`=1 latches the result (01 if `answer_correct`, else 10) and moves to JUDGE.
  - Otherwise, `TimeOut`=1 latches 11 and moves to JUDGE.
  - If both arrive in the same cycle, `answer_valid` wins.
  - `start` is ignored.
- JUDGE (1 cycle):
  - `round_done`=1.
  - `round` increments.
  - `last_result` is updated.
  - On a correct result, `score` += increment, clamped at 2^SCORE_W-1.
  - If the new round equals MAX_ROUNDS, go to OVER; else go to GAP with the prescaler cleared.
- GAP:
  - Prescaler runs, but `sec_tick` stays 0.
  - After GAP_TICKS internal wraps, go to LOAD.
  - `answer_valid` and `TimeOut` are ignored.
- OVER:
  - `game_over`=1.
  - score, round and last_result are held.
  - `start` clears them and moves to LOAD. `game_over` drops on that edge.
- `sec_tick` is 0 in every state except RUN.
- `reconfig` is 0 in every state except LOAD.
- Invalid `state_out` codes return to IDLE on the next clk.
- `ones` values above 9 are treated as 9.

Optional Feature:
TIME_BONUS_EN
- Defined: a correct answer adds 1 + `ones` (clamped to 9) to the score. `ones` is sampled in the RUN cycle where `answer_valid` is accepted, and the sum saturates.
- Undefined: a correct answer adds exactly 1, and `ones` is unused.

Test Plan:
Bench configuration: TICK_DIV=4, GAP_TICKS=1, MAX_ROUNDS=3, SCORE_W=8.
- Reset, then `start` pulse: LOAD is entered next edge with `reconfig` high for exactly 1 cycle. ARM lasts 1 cycle. In RUN, `sec_tick` pulses on RUN cycles 4, 8, 12.
- In RUN, `answer_valid`=1, `answer_correct`=1, `ones`=7: `round_done` pulses once; round=1; last_result=01; score=1 without the macro, 8 with TIME_BONUS_EN.
- `TimeOut` held at 1 through LOAD/ARM, then still high in RUN: no judge occurs during ARM; on the first RUN cycle last_result=11 and score is unchanged.
- `answer_valid`=1, `answer_correct`=0 and `TimeOut`=1 in the same RUN cycle: last_result=10 and score is unchanged.
- Three rounds played: `game_over`=1 with round=3. A subsequent `start` gives score=0, round=0, `reconfig` pulse, `game_over`=0. With SCORE_W=3 and TIME_BONUS_EN, two correct answers at `ones`=9 give score=7 (saturated).
- Assert `rst` mid-RUN: on the next edge all outputs are 0 and state_out=0. `sec_tick` stays 0 until a new `start` and RUN.
